// File: rtl/reset_seq_pkg.sv
// Shared state encoding and default sizing for the reset sequencer.
// RESET_SEQ_WDT_EN adds the watchdog width default.
package reset_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_SYNC    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_RUN     = 3'd2,
    ST_ASSERT  = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  localparam int DEF_NUM_DOM     = 4;
  localparam int DEF_STAGE_DLY   = 16;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_SYNC_STAGES = 3;
`ifdef RESET_SEQ_WDT_EN
  localparam int DEF_WDT_W       = 16;
`endif

endpackage

// File: rtl/reset_seq_ctrl_reset_sync.sv
// Asynchronous-assert / synchronous-deassert chain for the pad reset.
// rst_rel goes high SYNC_STAGES clock edges after rst_pad rises.
module reset_sync
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_pad,
  output logic rst_rel
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_pad) begin
    if (!rst_pad) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_rel = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_seq_ctrl.sv
// Ordered release of NUM_DOM reset domains with masked software re-reset.
// Define RESET_SEQ_WDT_EN to add the RUN-state watchdog (wdt_kick / wdt_expired).
module reset_seq_ctrl
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOM     = DEF_NUM_DOM,
  parameter int STAGE_DLY   = DEF_STAGE_DLY,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
`ifdef RESET_SEQ_WDT_EN
  ,
  parameter int WDT_W       = DEF_WDT_W
`endif
) (
  input  logic               clk,
  input  logic               rst_pad,
  input  logic               sw_rst_req,
  input  logic [NUM_DOM-1:0] sw_rst_mask,
`ifdef RESET_SEQ_WDT_EN
  input  logic               wdt_kick,
  output logic               wdt_expired,
`endif
  output logic               sw_rst_ack,
  output logic [NUM_DOM-1:0] dom_rstb,
  output logic               seq_done,
  output logic [STATE_W-1:0] state_o
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOM - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic [NUM_DOM-1:0] mask_q, mask_d;
  logic               ack_q, ack_d;
  logic               soft_q, soft_d;
  logic               rst_rel;
  logic               wdt_fire;

  reset_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_pad (rst_pad),
    .rst_rel (rst_rel)
  );

`ifdef RESET_SEQ_WDT_EN
  logic [WDT_W-1:0] wdt_cnt_q;
  logic             wdt_exp_q;

  assign wdt_fire = (state_q == ST_RUN) && (&wdt_cnt_q);

  always_ff @(posedge clk or negedge rst_pad) begin
    if (!rst_pad) begin
      wdt_cnt_q <= '0;
      wdt_exp_q <= 1'b0;
    end else begin
      if ((state_q != ST_RUN) || wdt_kick || wdt_fire) begin
        wdt_cnt_q <= '0;
      end else begin
        wdt_cnt_q <= wdt_cnt_q + 1'b1;
      end
      if (wdt_fire) begin
        wdt_exp_q <= 1'b1;
      end
    end
  end

  assign wdt_expired = wdt_exp_q;
`else
  assign wdt_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_pad) begin
    if (!rst_pad) begin
      state_q <= ST_SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      mask_q  <= '0;
      ack_q   <= 1'b0;
      soft_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      mask_q  <= mask_d;
      ack_q   <= ack_d;
      soft_q  <= soft_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    mask_d  = mask_q;
    ack_d   = ack_q;
    soft_d  = soft_q;

    // Four-phase handshake: ack falls once the requester has dropped req.
    if (ack_q && !sw_rst_req) begin
      ack_d = 1'b0;
    end

    case (state_q)
      ST_SYNC: begin
        if (rst_rel) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == CNT_LAST) begin
          dom_d[idx_q] = 1'b1;
          cnt_d        = '0;
          idx_d        = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
            idx_d   = '0;
            if (soft_q) begin
              ack_d  = 1'b1;
              soft_d = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        // Watchdog takes priority; a coincident request stays pending.
        if (wdt_fire) begin
          mask_d  = '1;
          state_d = ST_ASSERT;
        end else if (sw_rst_req && !ack_q) begin
          if (|sw_rst_mask) begin
            mask_d  = sw_rst_mask;
            soft_d  = 1'b1;
            state_d = ST_ASSERT;
          end else begin
            ack_d = 1'b1;
          end
        end
      end
      ST_ASSERT: begin
        dom_d   = dom_q & ~mask_q;
        cnt_d   = '0;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  assign dom_rstb   = dom_q;
  assign sw_rst_ack = ack_q;
  assign seq_done   = (state_q == ST_RUN);
  assign state_o    = state_q;

endmodule

// File: doc/reset_seq_ctrl.md
Name: reset_seq_ctrl

Overview:
- Reset sequencer downstream of the pad-reset/POR generator.
- Takes raw rst_pad, synchronises its deassertion, then releases NUM_DOM reset domains in a fixed order (index 0 first), with a programmable gap between domains. Typical order: mgmt core, housekeeping, FSIC IO, user project.
- Accepts four-phase software reset requests that re-reset a masked subset of domains while the others keep running.

Parameters:
- NUM_DOM, 4, number of reset domains (2..8).
- STAGE_DLY, 16, clk cycles between successive domain releases; also the soft-reset hold time (>=1).
- CNT_W, 8, delay counter width; must hold STAGE_DLY-1.
- SYNC_STAGES, 3, deassertion synchroniser depth (>=2).

Ports:
- clk  in  1  system clock.
- rst_pad  in  1  reset, asynchronous, active-low.
- sw_rst_req  in  1  software reset request, four-phase level.
- sw_rst_mask  in  NUM_DOM  domains to reset; sampled when a request is accepted.
- sw_rst_ack  out  1  request-complete acknowledge.
- dom_rstb  out  NUM_DOM  per-domain active-low resets.
- seq_done  out  1  all domains released, FSM in RUN.
- state_o  out  3  current FSM state, for debug.

Behaviour:
- Reset: rst_pad low asynchronously clears everything. dom_rstb=0, seq_done=0, sw_rst_ack=0, state=SYNC, counter=0, index=0, synchroniser cleared.
- Reset mid-operation (any state): same asynchronous clear, then the full sequence restarts.
- SYNC: wait for the synchroniser output to go high, SYNC_STAGES edges after rst_pad rises. Then go to RELEASE with cnt=0, idx=0.
- RELEASE: cnt increments each cycle.
  - When cnt==STAGE_DLY-1: set dom_rstb[idx]=1 (OR with current value), cnt=0, idx++.
  - Releasing idx NUM_DOM-1 moves the FSM to RUN.
  - Domain k rises exactly SYNC_STAGES+(k+1)*STAGE_DLY edges after rst_pad deassertion.
  - During a soft-reset release, the FSM steps through every index with the same timing; unmasked domains are already high and are unaffected.
- RUN: seq_done=1.
  - Request accepted when sw_rst_req=1 and sw_rst_ack=0.
  - mask!=0: latch mask, go to ASSERT, seq_done drops next cycle.
  - mask==0: assert sw_rst_ack next cycle, no state change.
- ASSERT (1 cycle): dom_rstb &= ~mask_q (all masked domains drop together), go to HOLD.
- HOLD: wait STAGE_DLY cycles, then RELEASE with idx=0.
- Acknowledge: on RUN re-entry after a soft reset, sw_rst_ack=1. It stays high until sw_rst_req is sampled low, then clears next cycle.
- Requests outside RUN are not accepted: no ack, and the request stays pending until RUN.
- State encoding: SYNC=0, RELEASE=1, RUN=2, ASSERT=3, HOLD=4. No other values are reachable.

Optional Feature:
- Macro: RESET_SEQ_WDT_EN.
- When defined:
  - Parameter WDT_W (default 16).
  - Ports wdt_kick (in, 1) and wdt_expired (out, 1, reset 0).
  - In RUN, the WDT counter increments every cycle; wdt_kick clears it.
  - On reaching all-ones, the controller performs ASSERT/HOLD/RELEASE with mask = all ones.
  - wdt_expired goes high and is sticky until rst_pad.
  - The counter is held at 0 outside RUN.
  - A WDT expiry and a software request in the same cycle: the WDT wins. No ack is given for the request; it stays pending.
- When undefined: no WDT ports, logic or parameter.

Decomposition:
- Package reset_seq_pkg: state encoding constants, state width (3), default parameter values.
- Sub-module reset_sync: asynchronous-assert / synchronous-deassert chain of SYNC_STAGES flops, cleared by rst_pad.

Test Plan:
- Power-up (NUM_DOM=4, STAGE_DLY=4, SYNC_STAGES=3), rst_pad rises at edge 0:
  - dom_rstb = 0001 at edge 7, 0011 at 11, 0111 at 15, 1111 at 19.
  - seq_done=1 from RUN entry.
- Soft reset, mask=0110 in RUN:
  - dom_rstb=1001 after ASSERT, held 4 cycles.
  - Bits 1 and 2 re-release at 4-cycle intervals.
  - sw_rst_ack=1 at RUN entry; ack clears one cycle after req drops.
  - Bits 0 and 3 never glitch.
- rst_pad pulsed low during RELEASE (dom_rstb=0011):
  - All outputs 0 immediately, without waiting for a clock.
  - Full sequence repeats with identical timing.
- Request raised during HOLD: ignored until RUN, then accepted. mask=0000 in RUN: ack next cycle, dom_rstb stays 1111.
- WDT (WDT_W=4, macro defined), no kicks:
  - After 15 RUN cycles, dom_rstb=0000, wdt_expired=1.
  - Re-release follows; periodic kicks prevent expiry.
